// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: lets NREQ writers share one enable-loaded register, granting one write at a time.
// Latency: REQ sampled in IDLE -> ENA_OUT next cycle -> ACK the cycle after -> IDLE; one write per 3 cycles.
// Backpressure: REQ is a level held until ACK; losers keep waiting and are served within NREQ-1 other grants.
// Build option: define REG_ARB_FIXED_PRI_EN for fixed priority (lowest index wins, no round-robin pointer).
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] WDATA,
  output logic               ENA_OUT,
  output logic [DW-1:0]      DATA_OUT,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    ACK,
  output logic               BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q,   win_d;
  logic              ena_q,   ena_d;
  logic [DW-1:0]     data_q,  data_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [NREQ-1:0]   ack_q,   ack_d;
  logic              busy_q,  busy_d;

  // Arbitration result for the current cycle (only consumed in IDLE)
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic [DW-1:0]     pick_dat;
  logic [NREQ-1:0]   win_oh;

`ifdef REG_ARB_FIXED_PRI_EN

  // Fixed priority: scan from the top so the lowest requesting index is the last to overwrite
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end

`else

  logic [IW-1:0]     ptr_q,   ptr_d;

  // Index reached by stepping 'off' places from 'base', wrapping at NREQ
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return IW'(s);
  endfunction

  // Round-robin: scan offsets from far to near so the requester closest to ptr wins
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (REQ[rr_idx(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx(ptr_q, k);
      end
    end
  end

  // Pointer moves just past the winner as its write completes
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_DONE) begin
      ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
    end
  end

  // Round-robin pointer register; reset (including mid-write) returns it to requester 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  // Decode the candidate winner into a one-hot grant and select its write data
  always_comb begin
    pick_oh  = '0;
    pick_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_dat   = WDATA[DW*i +: DW];
      end
    end
  end

  // One-hot of the latched winner, used for GNT/ACK while the write is in flight
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == IW'(i)) begin
        win_oh[i] = 1'b1;
      end
    end
  end

  // FSM next state and next registered outputs; outputs reflect the state being entered
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ena_d   = 1'b0;
    data_d  = data_q;   // DATA_OUT holds in IDLE; ENA_OUT is the only qualifier
    gnt_d   = '0;
    ack_d   = '0;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          // Winner and its data are captured here so later WDATA/REQ changes cannot disturb the write
          state_d = S_WRITE;
          win_d   = pick_idx;
          data_d  = pick_dat;
          ena_d   = 1'b1;
          gnt_d   = pick_oh;
          busy_d  = 1'b1;
        end
      end
      S_WRITE: begin
        // Register loads on the edge leaving WRITE; acknowledge in the same cycle it holds the new value
        state_d = S_DONE;
        gnt_d   = win_oh;
        ack_d   = win_oh;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any write in progress and suppresses ACK
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ena_q   <= 1'b0;
      data_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ena_q   <= ena_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ENA_OUT  = ena_q;
  assign DATA_OUT = data_q;
  assign GNT      = gnt_q;
  assign ACK      = ack_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed stimulus with a scoreboard of expected writes.
// The downstream 8-bit enable-loaded register is instantiated here behaviourally.
// Build with REG_ARB_FIXED_PRI_EN defined to exercise the fixed-priority variant.
module tb_reg_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  typedef struct {
    int         idx;
    logic [7:0] dat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic              ena_out;
  logic [DW-1:0]     data_out;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [DW-1:0]     r_reg;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   cur_vld = 1'b0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .WDATA    (wdata),
    .ENA_OUT  (ena_out),
    .DATA_OUT (data_out),
    .GNT      (gnt),
    .ACK      (ack),
    .BUSY     (busy)
  );

  // Shared register: MUX + DFF per bit, loaded on ENA, same clock/reset as the arbiter
  always @(posedge clk) begin
    if (rst) r_reg <= '0;
    else if (ena_out) r_reg <= data_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req_v, $time);
  endtask

  // Monitor: each ENA_OUT pulse pops the next expected write; the following cycle must ACK it
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      cur_vld <= 1'b0;
    end else begin
      if (cur_vld) begin
        chk($sformatf("ack_r%0d", cur.idx), ack, 32'd1 << cur.idx);
        chk($sformatf("gnt_done_r%0d", cur.idx), gnt, 32'd1 << cur.idx);
        chk("ena_done", ena_out, 0);
        chk("busy_done", busy, 1);
        chk($sformatf("reg_after_r%0d", cur.idx), r_reg, cur.dat);
        cur_vld <= 1'b0;
      end else begin
        chk("ack_quiet", ack, 0);
      end
      if (ena_out) begin
        if (exp_q.size() == 0) begin
          chk("write_queue_depth", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("data_r%0d", e.idx), data_out, e.dat);
          chk($sformatf("gnt_write_r%0d", e.idx), gnt, 32'd1 << e.idx);
          chk("busy_write", busy, 1);
          cur     <= e;
          cur_vld <= 1'b1;
        end
      end
    end
  end

  // Wait (bounded) for ACK[idx]; cyc counts negedges until it is seen, bc counts BUSY cycles
  task automatic wait_ack(input int idx, input bit drop, output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
      if (ack[idx]) begin
        if (drop) req[idx] = 1'b0;
        return;
      end
    end
    chk($sformatf("ack_timeout_r%0d", idx), ack, 32'd1 << idx);
    cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int  cyc;
    int  bc;
    bit  seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ena", ena_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg", r_reg, 0);

`ifdef REG_ARB_FIXED_PRI_EN
    // Requester 1 keeps re-requesting and always beats requester 3
    @(posedge clk); #1;
    wdata[15:8]  = 8'h5A;
    wdata[31:24] = 8'hA3;
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{1, 8'h5A});
      wait_ack(1, 1'b0, cyc, bc);
      chk($sformatf("fixed_gap_%0d", i), cyc, 3);
    end
    req[1] = 1'b0;
    exp_q.push_back('{3, 8'hA3});
    wait_ack(3, 1'b1, cyc, bc);
    chk("fixed_r3_lat", cyc, 3);
`else
    // Single request from requester 1
    @(posedge clk); #1;
    wdata[15:8] = 8'hA5;
    req = 4'b0010;
    exp_q.push_back('{1, 8'hA5});
    wait_ack(1, 1'b1, cyc, bc);
    chk("single_latency", cyc, 3);
    chk("single_busy_cycles", bc, 2);
    @(negedge clk);
    chk("single_busy_after", busy, 0);
    chk("single_reg", r_reg, 8'hA5);

    // All four requesting from PTR=0: order 0,1,2,3, three cycles apart
    do_reset();
    @(posedge clk); #1;
    wdata = 32'h44332211;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'(17 * (i + 1));
      exp_q.push_back('{i, d});
    end
    for (int i = 0; i < 4; i++) begin
      wait_ack(i, 1'b1, cyc, bc);
      chk($sformatf("rr_gap_%0d", i), cyc, 3);
    end

    // Serve 2 (PTR->3), then 1001: 3 before 0 (PTR wraps to 0, then 1)
    @(posedge clk); #1;
    wdata[23:16] = 8'h55;
    req = 4'b0100;
    exp_q.push_back('{2, 8'h55});
    wait_ack(2, 1'b1, cyc, bc);
    chk("wrap_pre_lat", cyc, 3);
    @(posedge clk); #1;
    wdata[31:24] = 8'h66;
    wdata[7:0]   = 8'h77;
    req = 4'b1001;
    exp_q.push_back('{3, 8'h66});
    exp_q.push_back('{0, 8'h77});
    wait_ack(3, 1'b1, cyc, bc);
    chk("wrap_r3_lat", cyc, 3);
    wait_ack(0, 1'b1, cyc, bc);
    chk("wrap_r0_gap", cyc, 3);
    // PTR now 1: requester 1 beats requester 0
    @(posedge clk); #1;
    wdata[7:0]  = 8'h88;
    wdata[15:8] = 8'h99;
    req = 4'b0011;
    exp_q.push_back('{1, 8'h99});
    exp_q.push_back('{0, 8'h88});
    wait_ack(1, 1'b1, cyc, bc);
    chk("ptr1_r1_lat", cyc, 3);
    wait_ack(0, 1'b1, cyc, bc);
    chk("ptr1_r0_gap", cyc, 3);

    // Data latched at grant; REQ dropped and WDATA changed during WRITE
    @(posedge clk); #1;
    wdata[7:0] = 8'h3C;
    req = 4'b0001;
    exp_q.push_back('{0, 8'h3C});
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (ena_out) seen = 1'b1;
    end
    if (!seen) chk("latch_ena_timeout", ena_out, 1);
    wdata[7:0] = 8'hFF;
    req = 4'b0000;
    wait_ack(0, 1'b1, cyc, bc);
    chk("latch_ack_lat", cyc, 1);
    repeat (3) @(negedge clk);
    chk("latch_reg_hold", r_reg, 8'h3C);
    chk("latch_data_hold", data_out, 8'h3C);

    // Reset on the edge that ends WRITE: write aborted, no ACK, PTR back to 0
    @(posedge clk); #1;
    wdata[31:24] = 8'h5E;
    req = 4'b1000;
    @(posedge clk); #1;
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    chk("abort_pre_ena", ena_out, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ena", ena_out, 0);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_gnt", gnt, 0);
    chk("abort_reg", r_reg, 0);
    chk("abort_data", data_out, 0);
    // PTR=0 gives requester 0 priority over 2 (PTR=1 would pick 2)
    @(posedge clk); #1;
    wdata[7:0]   = 8'hAB;
    wdata[23:16] = 8'hCD;
    req = 4'b0101;
    exp_q.push_back('{0, 8'hAB});
    exp_q.push_back('{2, 8'hCD});
    wait_ack(0, 1'b1, cyc, bc);
    chk("post_rst_r0_lat", cyc, 3);
    wait_ack(2, 1'b1, cyc, bc);
    chk("post_rst_r2_gap", cyc, 3);
    @(posedge clk); #1;
    wdata[23:16] = 8'hE7;
    req = 4'b0100;
    exp_q.push_back('{2, 8'hE7});
    wait_ack(2, 1'b1, cyc, bc);
    chk("post_rst_r2_single", cyc, 3);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
